sensor_conditioner: RTL and testbench

Front-end conditioning stage between the raw board switches and the irrigation controller top level. Synchronises and debounces the seven raw sensor/selector inputs and checks the tank-level sensors for plausibility with a small fault FSM. Checks the soil-moisture pair for contradiction. Drives the clean h, m, l, us, ua, t and selector signals that the alarm, inlet-valve, drip, sprinkler and display logic consume.

---
 rtl/sensor_pkg.sv | 41 ++++
 rtl/debouncer.sv | 59 +++++
 rtl/sensor_conditioner.sv | 170 +++++++++++++++++
 tb/tb_sensor_conditioner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and helpers for the sensor conditioning front end.
package sensor_pkg;

  // Level plausibility FSM; the unused code 2'b11 is steered back to LvlOk.
  typedef enum logic [1:0] {
    LvlOk      = 2'b00,
    LvlSuspect = 2'b01,
    LvlFault   = 2'b10
  } level_state_e;

  // Plausible tank patterns, ordered {h, m, l}.
  localparam logic [2:0] LvlEmpty = 3'b000;
  localparam logic [2:0] LvlLow   = 3'b001;
  localparam logic [2:0] LvlMid   = 3'b011;
  localparam logic [2:0] LvlFull  = 3'b111;

  // Positions of the inputs inside the packed raw/debounced vectors.
  localparam int unsigned NumInputs = 7;
  localparam int unsigned IdxH      = 0;
  localparam int unsigned IdxM      = 1;
  localparam int unsigned IdxL      = 2;
  localparam int unsigned IdxUs     = 3;
  localparam int unsigned IdxUa     = 4;
  localparam int unsigned IdxT      = 5;
  localparam int unsigned IdxSel    = 6;

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  // Water can only be present at a level if every lower level is also wet,
  // which is the same as rejecting (h & ~m) | (m & ~l).
  function automatic logic level_valid(input logic [2:0] hml);
    return (hml == LvlEmpty) || (hml == LvlLow) || (hml == LvlMid) || (hml == LvlFull);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a counting debouncer for one raw input.
module debouncer
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            sync_a, sync_b;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous switch into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count,
  // so the counter tops out at CntLast and never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_b != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the seven board inputs, vets tank-level plausibility, masks contradictory
// soil readings and flags any change of the clean outputs.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FAULT_CYCLES    = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic h_raw,
  input  logic m_raw,
  input  logic l_raw,
  input  logic us_raw,
  input  logic ua_raw,
  input  logic t_raw,
  input  logic sel_raw,
  output logic h,
  output logic m,
  output logic l,
  output logic us,
  output logic ua,
  output logic t,
  output logic selector,
  output logic level_fault,
  output logic soil_fault,
  output logic changed
);

  // One spare count so leaving FAULT takes FAULT_CYCLES+1 valid samples, mirroring
  // the extra OK->SUSPECT edge on the way in.
  localparam int unsigned    FcntW      = cnt_width(FAULT_CYCLES + 1);
  localparam logic [FcntW-1:0] SuspectMax = FcntW'(FAULT_CYCLES - 1);
  localparam logic [FcntW-1:0] FaultMax   = FcntW'(FAULT_CYCLES);
  localparam logic [FcntW-1:0] FcntOne    = FcntW'(1);

  logic [NumInputs-1:0] raw_vec, db_vec;
  logic [2:0]           lvl_pat;
  logic                 lvl_ok;
  logic                 usd, uad;

  level_state_e         state_q, state_d;
  logic [FcntW-1:0]     fcnt_q, fcnt_d;

  // level_q is both the h/m/l output and the last plausible pattern.
  logic [2:0]           level_q, level_d;
  logic                 us_q, ua_q, soil_fault_q, t_q, sel_q;
  logic [NumInputs-1:0] clean, clean_prev_q;
  logic                 changed_q;

  assign raw_vec = {sel_raw, t_raw, ua_raw, us_raw, l_raw, m_raw, h_raw};

  for (genvar i = 0; i < NumInputs; i++) begin : g_deb
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (raw_vec[i]),
      .dout (db_vec[i])
    );
  end

  assign lvl_pat = {db_vec[IdxH], db_vec[IdxM], db_vec[IdxL]};
  assign lvl_ok  = level_valid(lvl_pat);
  assign usd     = db_vec[IdxUs];
  assign uad     = db_vec[IdxUa];

  // Level FSM next state: SUSPECT counts invalid samples, FAULT counts valid ones.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      LvlOk: begin
        if (!lvl_ok) begin
          state_d = LvlSuspect;
          fcnt_d  = '0;
        end
      end
      LvlSuspect: begin
        if (lvl_ok) begin
          state_d = LvlOk;
          fcnt_d  = '0;
        end else if (fcnt_q == SuspectMax) begin
          state_d = LvlFault;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FcntOne;
        end
      end
      LvlFault: begin
        if (!lvl_ok) begin
          fcnt_d = '0;
        end else if (fcnt_q == FaultMax) begin
          state_d = LvlOk;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FcntOne;
        end
      end
      default: begin
        state_d = LvlOk;
        fcnt_d  = '0;
      end
    endcase
  end

  // Level FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LvlOk;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Only a plausible pattern seen while OK reaches the outputs; otherwise hold.
  always_comb begin
    level_d = level_q;
    if ((state_q == LvlOk) && lvl_ok) begin
      level_d = lvl_pat;
    end
  end

  // Output register; a wet+dry soil contradiction suppresses both demands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q      <= '0;
      us_q         <= 1'b0;
      ua_q         <= 1'b0;
      soil_fault_q <= 1'b0;
      t_q          <= 1'b0;
      sel_q        <= 1'b0;
    end else begin
      level_q      <= level_d;
      us_q         <= usd & ~uad;
      ua_q         <= uad & ~usd;
      soil_fault_q <= usd & uad;
      t_q          <= db_vec[IdxT];
      sel_q        <= db_vec[IdxSel];
    end
  end

  assign clean = {sel_q, t_q, ua_q, us_q, level_q[0], level_q[1], level_q[2]};

  // One pulse for any change of the clean outputs, one cycle after the update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean_prev_q <= '0;
      changed_q    <= 1'b0;
    end else begin
      clean_prev_q <= clean;
      changed_q    <= (clean != clean_prev_q);
    end
  end

  assign h           = level_q[2];
  assign m           = level_q[1];
  assign l           = level_q[0];
  assign us          = us_q;
  assign ua          = ua_q;
  assign t           = t_q;
  assign selector    = sel_q;
  assign soil_fault  = soil_fault_q;
  assign level_fault = (state_q == LvlFault);
  assign changed     = changed_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// stimulus, all compared every cycle against a behavioural model.
module tb_sensor_conditioner;

  localparam int D = 4;
  localparam int F = 8;

  logic clk = 1'b0;
  logic reset;
  logic h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw, sel_raw;
  logic h, m, l, us, ua, t, selector, level_fault, soil_fault, changed;

  int vectors = 0;
  int miscompares = 0;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .FAULT_CYCLES   (F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .h_raw      (h_raw),
    .m_raw      (m_raw),
    .l_raw      (l_raw),
    .us_raw     (us_raw),
    .ua_raw     (ua_raw),
    .t_raw      (t_raw),
    .sel_raw    (sel_raw),
    .h          (h),
    .m          (m),
    .l          (l),
    .us         (us),
    .ua         (ua),
    .t          (t),
    .selector   (selector),
    .level_fault(level_fault),
    .soil_fault (soil_fault),
    .changed    (changed)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Inputs ordered {sel, t, ua, us, l, m, h}.
  logic [6:0] m_d1, m_d2;      // raw samples one and two edges old
  logic [6:0] m_last;          // last synchronised sample per input
  logic [6:0] m_db;            // debounced values
  int         m_run[7];        // length of the current run of identical samples
  logic [2:0] m_hml;           // {h, m, l}
  logic       m_us, m_ua, m_sf, m_t, m_sel, m_chg, m_fault, m_prev_pv;
  int         m_irun, m_vrun;  // consecutive invalid / valid level samples
  logic [6:0] m_clean_prev;

  function automatic logic [6:0] raw_now();
    return {sel_raw, t_raw, ua_raw, us_raw, l_raw, m_raw, h_raw};
  endfunction

  function automatic logic [6:0] model_clean();
    return {m_sel, m_t, m_ua, m_us, m_hml[0], m_hml[1], m_hml[2]};
  endfunction

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_last = '0; m_db = '0;
    for (int i = 0; i < 7; i++) m_run[i] = 0;
    m_hml = '0; m_us = 0; m_ua = 0; m_sf = 0; m_t = 0; m_sel = 0; m_chg = 0;
    m_fault = 0; m_prev_pv = 1; m_irun = 0; m_vrun = 0; m_clean_prev = '0;
  endtask

  // One rising edge: outputs are functions of the debounced values before the edge.
  task automatic model_step();
    logic [6:0] sight, clean_now;
    logic [2:0] p;
    logic       pv, fault_old;
    clean_now    = model_clean();
    m_chg        = (clean_now != m_clean_prev);
    m_clean_prev = clean_now;

    p  = {m_db[0], m_db[1], m_db[2]};
    pv = (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
    if (pv) begin
      m_vrun = (m_vrun < 1000) ? m_vrun + 1 : m_vrun;
      m_irun = 0;
    end else begin
      m_irun = (m_irun < 1000) ? m_irun + 1 : m_irun;
      m_vrun = 0;
    end
    // Fault after F+1 invalid samples in a row; cleared after F+1 valid samples.
    fault_old = m_fault;
    if (m_fault) m_fault = !(m_vrun >= F + 1);
    else m_fault = (m_irun >= F + 1);
    // Outputs follow the pattern once it has been plausible twice running, outside a fault.
    if (!fault_old && m_prev_pv && pv) m_hml = p;
    m_prev_pv = pv;

    m_sf  = m_db[3] & m_db[4];
    m_us  = m_db[3] & ~m_db[4];
    m_ua  = m_db[4] & ~m_db[3];
    m_t   = m_db[5];
    m_sel = m_db[6];

    // A debounced bit adopts a value once the synchronised input has shown it D times running.
    sight = m_d2;
    for (int i = 0; i < 7; i++) begin
      if (sight[i] == m_last[i]) m_run[i] = (m_run[i] < D) ? m_run[i] + 1 : m_run[i];
      else m_run[i] = 1;
      m_last[i] = sight[i];
      if (m_run[i] >= D && sight[i] != m_db[i]) m_db[i] = sight[i];
    end
    m_d2 = m_d1;
    m_d1 = raw_now();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [9:0] act, exp;
    act = {level_fault, soil_fault, changed, selector, t, ua, us, l, m, h};
    exp = {m_fault, m_sf, m_chg, model_clean()};
    check("model", {22'd0, act}, {22'd0, exp});
  endtask

  // Advance one clock: model at the rising edge, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_raw(input logic [6:0] v);
    {sel_raw, t_raw, ua_raw, us_raw, l_raw, m_raw, h_raw} = v;
  endtask

  int chg_seen;
  logic [6:0] rv;

  initial begin
    reset = 1'b1;
    set_raw('0);
    model_reset();
    cycles(2);
    check("reset_outputs", {22'd0, level_fault, soil_fault, changed, selector, t, ua, us, l, m, h},
          32'd0);
    reset = 1'b0;

    // S1: l rises 7 edges after the raw edge, single changed pulse.
    l_raw = 1'b1;
    cycles(6);
    check("s1_l_early", {31'd0, l}, 32'd0);
    cycle();
    check("s1_l_rise", {29'd0, h, m, l}, 32'd1);
    check("s1_chg_not_yet", {31'd0, changed}, 32'd0);
    cycle();
    check("s1_chg_pulse", {31'd0, changed}, 32'd1);
    cycle();
    check("s1_chg_one_cycle", {31'd0, changed}, 32'd0);

    // S2: 3-cycle glitch on us_raw is filtered.
    us_raw = 1'b1;
    cycles(3);
    us_raw = 1'b0;
    chg_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chg_seen += int'(changed);
    end
    check("s2_glitch_us", {31'd0, us}, 32'd0);
    check("s2_glitch_chg", chg_seen, 32'd0);

    // S3: 111 settled then m drops -> fault 9 edges after the debounced 101.
    h_raw = 1'b1; m_raw = 1'b1;
    cycles(12);
    check("s3_full", {29'd0, h, m, l}, 32'd7);
    m_raw = 1'b0;
    cycles(14);
    check("s3_fault_early", {31'd0, level_fault}, 32'd0);
    cycle();
    check("s3_fault_rise", {31'd0, level_fault}, 32'd1);
    check("s3_hold", {29'd0, h, m, l}, 32'd7);

    // S4: 011 with a one-cycle raw 101 glitch; fault clears 9 edges after debounced 011.
    h_raw = 1'b0; m_raw = 1'b1;
    cycles(5);
    h_raw = 1'b1; m_raw = 1'b0;
    cycle();
    h_raw = 1'b0; m_raw = 1'b1;
    cycles(8);
    check("s4_fault_held", {31'd0, level_fault}, 32'd1);
    check("s4_hold", {29'd0, h, m, l}, 32'd7);
    cycle();
    check("s4_fault_fall", {31'd0, level_fault}, 32'd0);
    cycle();
    check("s4_level", {29'd0, h, m, l}, 32'd3);

    // S5: soil contradiction masks demand; releasing ua restores us.
    us_raw = 1'b1; ua_raw = 1'b1;
    cycles(10);
    check("s5_soil_fault", {29'd0, soil_fault, us, ua}, 32'd4);
    ua_raw = 1'b0;
    cycles(6);
    check("s5_soil_held", {30'd0, soil_fault, us}, 32'd2);
    cycle();
    check("s5_soil_clear", {30'd0, soil_fault, us}, 32'd1);

    // S6: reset in SUSPECT with a debounce count in flight discards everything.
    l_raw = 1'b0;
    cycles(7);
    t_raw = 1'b1;
    cycles(4);
    check("s6_suspect_no_fault", {31'd0, level_fault}, 32'd0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("s6_async_reset", {22'd0, level_fault, soil_fault, changed, selector, t, ua, us, l, m, h},
          32'd0);
    set_raw(7'b0000100);
    cycles(2);
    reset = 1'b0;
    cycles(6);
    check("s6_l_early", {31'd0, l}, 32'd0);
    cycle();
    check("s6_l_rise", {29'd0, h, m, l}, 32'd1);
    cycles(12);
    check("s6_no_fault", {31'd0, level_fault}, 32'd0);

    // Random phase: short and long holds, any level pattern, one mid-run reset.
    for (int seg = 0; seg < 220; seg++) begin
      rv = 7'($urandom);
      if ($urandom_range(0, 3) != 0) rv[2:0] = raw_now() & 3'b111;
      set_raw(rv);
      if (seg == 110) begin
        #2 reset = 1'b1;
        model_reset();
        cycles(2);
        reset = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) cycles($urandom_range(12, 30));
      else cycles($urandom_range(1, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
